router_pkt_fifo: RTL

Parametrised, packet-aware synchronous FIFO for the router output channels. It stores DATA_W-bit bytes plus a header tag per entry. On the read side it tracks packet boundaries, so the read controller knows how many bytes remain in the packet being drained, how many complete headers are queued, and when the parity byte leaves. One instance sits between the router's register/FSM write path and each destination port.

---
 rtl/router_pkg.sv | 18 +
 rtl/router_pkt_fifo_if.sv | 34 +++
 rtl/router_fifo_mem.sv | 38 +++
 rtl/router_pkt_fifo.sv | 123 ++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: header byte layout and the payload-length helper.
package router_pkg;

  localparam int unsigned HDR_ADDR_W  = 2;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned HDR_BYTE_W  = 8;

  typedef struct packed {
    logic [HDR_BYTE_W-HDR_ADDR_W-1:0] len;
    logic [HDR_ADDR_W-1:0]            addr;
  } hdr_t;

  // Caller zero-extends the byte, so this works for any byte width up to 64.
  function automatic logic [63:0] hdr_len(input logic [63:0] b);
    return b >> HDR_LEN_LSB;
  endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read bus between a router channel producer/consumer and router_pkt_fifo.
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              we;
  logic [DATA_W-1:0] din;
  logic              lfd;
  logic              re;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              rd_eop;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic [CW-1:0]     count;
  logic [CW-1:0]     pkt_cnt;
  logic [DATA_W-2:0] rd_rem;

  modport master (
    output we, din, lfd, re,
    input  dout, dout_vld, rd_eop, empty, full, almost_full, count, pkt_cnt, rd_rem
  );

  modport slave (
    input  we, din, lfd, re,
    output dout, dout_vld, rd_eop, empty, full, almost_full, count, pkt_cnt, rd_rem
  );

endinterface

// File: rtl/router_fifo_mem.sv
// {tag, data} storage with registered read data plus a combinational view of the head entry.
module router_fifo_mem #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-2:0] rdata,
  output logic [WIDTH-1:0] head_c
);

  logic [WIDTH-2:0] data_mem [DEPTH];
  logic [DEPTH-1:0] tag_mem;

  // Data column is never cleared; only tags are.
  always_ff @(posedge clk) begin
    if (we) data_mem[waddr] <= wdata[WIDTH-2:0];
  end

  always_ff @(posedge clk) begin
    if (clr)     tag_mem        <= '0;
    else if (we) tag_mem[waddr] <= wdata[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= data_mem[raddr];
  end

  assign head_c = {tag_mem[raddr], data_mem[raddr]};

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output channel.
// Define ROUTER_FIFO_ERR_EN to add sticky ovf_err/udf_err outputs.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_LVL = DEPTH - 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic soft_rst,
`ifdef ROUTER_FIFO_ERR_EN
  output logic ovf_err,
  output logic udf_err,
`endif
  router_pkt_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = DATA_W - 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     pkt_cnt_q;
  logic [RW-1:0]     rd_rem_q;
  logic              dout_vld_q;
  logic              rd_eop_q;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W:0]   head_c;

  logic              flush_c;
  logic              empty_c;
  logic              full_c;
  logic              wr_ok_c;
  logic              rd_ok_c;
  logic              head_tag_c;
  logic [RW-1:0]     rem_load_c;

  assign flush_c    = !rstn || soft_rst;
  assign empty_c    = (wr_ptr == rd_ptr);
  assign full_c     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign wr_ok_c    = bus.we && !full_c;
  assign rd_ok_c    = bus.re && !empty_c;
  assign head_tag_c = head_c[DATA_W];
  // Payload bytes plus the trailing parity byte.
  assign rem_load_c = RW'(hdr_len(64'(head_c[DATA_W-1:0])) + 64'd1);

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .clr    (flush_c),
    .we     (wr_ok_c && !flush_c),
    .waddr  (wr_ptr[PW-2:0]),
    .wdata  ({bus.lfd, bus.din}),
    .re     (rd_ok_c && !flush_c),
    .raddr  (rd_ptr[PW-2:0]),
    .rdata  (rdata),
    .head_c (head_c)
  );

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (flush_c) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + PW'(1);
      if (wr_ok_c && !rd_ok_c)      count_q <= count_q + CW'(1);
      else if (!wr_ok_c && rd_ok_c) count_q <= count_q - CW'(1);
    end
  end

  // Packet tracking on the read side.
  always_ff @(posedge clk) begin
    if (flush_c) begin
      pkt_cnt_q  <= '0;
      rd_rem_q   <= '0;
      dout_vld_q <= 1'b0;
      rd_eop_q   <= 1'b0;
    end else begin
      if ((wr_ok_c && bus.lfd) && !(rd_ok_c && head_tag_c))      pkt_cnt_q <= pkt_cnt_q + CW'(1);
      else if (!(wr_ok_c && bus.lfd) && (rd_ok_c && head_tag_c)) pkt_cnt_q <= pkt_cnt_q - CW'(1);
      if (rd_ok_c) begin
        if (head_tag_c)            rd_rem_q <= rem_load_c;
        else if (rd_rem_q != '0)   rd_rem_q <= rd_rem_q - RW'(1);
      end
      dout_vld_q <= rd_ok_c;
      rd_eop_q   <= rd_ok_c && !head_tag_c && (rd_rem_q == RW'(1));
    end
  end

`ifdef ROUTER_FIFO_ERR_EN
  // Sticky protocol violation flags.
  always_ff @(posedge clk) begin
    if (flush_c) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (bus.we && full_c)  ovf_err <= 1'b1;
      if (bus.re && empty_c) udf_err <= 1'b1;
    end
  end
`endif

  assign bus.dout        = rdata;
  assign bus.dout_vld    = dout_vld_q;
  assign bus.rd_eop      = rd_eop_q;
  assign bus.empty       = empty_c;
  assign bus.full        = full_c;
  assign bus.almost_full = (count_q >= CW'(AFULL_LVL));
  assign bus.count       = count_q;
  assign bus.pkt_cnt     = pkt_cnt_q;
  assign bus.rd_rem      = rd_rem_q;

endmodule
